// File: rtl/seq_div_unit.sv
// Signed WIDTH-bit restoring divider for DIV: quotient to ZLO, remainder to ZHI.
// Latency: done pulses 34 edges after the start edge (1 edge for divide-by-zero; 2 edges with SEQ_DIV_EARLY_OUT_EN when |dividend| < |divisor|).
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped, results hold until the next accepted start.
module seq_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_b;
  // rem_r holds the partial remainder; quo_r starts as |dividend| and is
  // shifted out the top while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic             div_zero_in;
  logic             early_out;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Operand magnitudes at start and the trial subtraction for one restoring step.
  // The magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    mag_a_in    = dividend[WIDTH-1] ? -dividend : dividend;
    mag_b_in    = divisor[WIDTH-1]  ? -divisor  : divisor;
    div_zero_in = (divisor == '0);
    shifted     = {rem_r, quo_r[WIDTH-1]};
    trial       = shifted - {1'b0, mag_b};
`ifdef SEQ_DIV_EARLY_OUT_EN
    early_out   = !div_zero_in && (mag_a_in < mag_b_in);
`else
    early_out   = 1'b0;
`endif
  end

  // Control sequencer and datapath: IDLE -> RUN (WIDTH steps) -> FIX -> DONE -> IDLE.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      mag_b       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            sign_a      <= dividend[WIDTH-1];
            sign_b      <= divisor[WIDTH-1];
            mag_b       <= mag_b_in;
            cnt         <= '0;
            div_by_zero <= div_zero_in;
            if (div_zero_in) begin
              // Quotient saturates to all ones; the dividend passes through as remainder.
              quotient  <= '1;
              remainder <= dividend;
              rem_r     <= '0;
              quo_r     <= mag_a_in;
              done      <= 1'b1;
              state     <= S_DONE;
            end else if (early_out) begin
              // |dividend| < |divisor|: quotient magnitude is zero, skip the iterations.
              rem_r <= mag_a_in;
              quo_r <= '0;
              state <= S_FIX;
            end else begin
              rem_r <= '0;
              quo_r <= mag_a_in;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Restore on a negative trial; the quotient bit is the inverted borrow.
          rem_r <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          // Truncating division: quotient sign is the sign XOR, remainder follows the dividend.
          quotient  <= (sign_a ^ sign_b) ? -quo_r : quo_r;
          remainder <= sign_a ? -rem_r : rem_r;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
